br_resolve: RTL
===============

Name: br_resolve

Overview:
- Consumer end of the branch-compare interface.
- Drives `br_unsigned` to the branch comparator from the branch funct3 and takes back `br_less`/`br_equal`.
- Resolves conditional branches, JAL and JALR against the fetch stage's prediction.
- On a mispredict, issues a registered PC redirect and a multi-cycle flush, sequenced by a small FSM.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 2, number of cycles `flush` is held after a redirect (≥1).
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- br_valid  in  1  branch/jump presented this cycle.
- br_ready  out  1  block can accept; high only in IDLE.
- br_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved.
- br_funct3  in  3  branch funct3.
- pred_taken  in  1  fetch-stage prediction for this instruction.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  sign-extended immediate.
- rs1_data  in  XLEN  JALR base.
- br_unsigned  out  1  combinational, = `br_funct3[1]`; to comparator.
- br_less  in  1  from comparator.
- br_equal  in  1  from comparator.
- redirect_valid  out  1  one-cycle pulse, new fetch PC.
- redirect_pc  out  XLEN  registered redirect target.
- flush  out  1  squash younger instructions.
- misalign_exc  out  1  one-cycle pulse, taken target with bit1 set.
- illegal_br  out  1  one-cycle pulse, bad funct3/kind.
- branch_cnt  out  CNT_W  resolved branches (optional feature).
- mispred_cnt  out  CNT_W  redirects issued (optional feature).

Behaviour:
Reset:
- On `i_rst` at the clock edge:
  - state = IDLE.
  - `redirect_valid`, `redirect_pc`, `flush`, `misalign_exc`, `illegal_br` = 0.
  - Counters = 0.
- Reset during FLUSH aborts the flush immediately; the next cycle is IDLE with `br_ready` = 1.

Accept and decode:
- Accept occurs on `br_valid & br_ready` at a rising edge (cycle N).
- Conditional branch decode:
  - 000 taken = equal.
  - 001 taken = ~equal.
  - 100 / 110 taken = less.
  - 101 / 111 taken = ~less.
  - 010 / 011 are illegal.
- JAL and JALR are always taken. Kind 11 is illegal.

Targets (all arithmetic modulo 2^XLEN, wrap-around ignored):
- Branch / JAL target = pc + imm.
- JALR target = (rs1_data + imm) & ~1.
- Fall-through = pc + 4.

Outcome priority, evaluated at accept:
1. Illegal: `illegal_br` pulses in N+1. No redirect, no flush, stay IDLE.
2. Taken and target[1] = 1: `misalign_exc` pulses in N+1. No redirect, no flush, stay IDLE.
3. Mispredict — cond branch with taken ≠ `pred_taken`, or JAL with `pred_taken` = 0, or any JALR (JALR is always redirected):
   - In N+1: `redirect_valid` = 1 for exactly one cycle, `redirect_pc` = taken ? target : pc+4.
   - Enter FLUSH.
4. Correct prediction: no output activity, stay IDLE; back-to-back accepts allowed.

FSM:
- IDLE:
  - `br_ready` = 1.
  - Outcome 3 → FLUSH, load flush counter with FLUSH_CYCLES−1.
- FLUSH:
  - `flush` = 1, `br_ready` = 0.
  - `br_valid` is ignored (not accepted).
  - Counter decrements each cycle; at 0 → IDLE.
- Timing: `flush` is high in cycles N+1 .. N+FLUSH_CYCLES, and `br_ready` is high again in N+FLUSH_CYCLES+1.
- `redirect_pc` holds its value until the next redirect.

Optional Feature:
Macro `BR_PERF_CNT_EN`.
- When defined:
  - `branch_cnt` +1 on every accepted, non-illegal transaction.
  - `mispred_cnt` +1 on every redirect.
  - Both saturate at all-ones and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- BEQ, pc=0x100, imm=0x20, equal=1, pred_taken=0 → `br_unsigned`=0; N+1: `redirect_valid`=1, `redirect_pc`=0x120; `flush` high 2 cycles; `br_ready` low 2 cycles.
- BLTU, pc=0x200, less=0, pred_taken=0, followed by BNE, equal=0, pred_taken=1 on the next cycle → `br_unsigned`=1 then 0; both accepted back-to-back; no redirect, no flush.
- JALR, rs1=0x1003, imm=0x4 → `redirect_pc`=0x1006 → bit1 set → `misalign_exc` pulse, no redirect; same with rs1=0x1001 → `redirect_pc`=0x1004, redirect issued.
- funct3=010, br_valid=1 → `illegal_br` pulse only; br_kind=11 → same.
- Mispredict, then `i_rst` asserted in N+1 → next cycle: `flush`=0, `br_ready`=1, `redirect_pc`=0, counters=0.
- With `BR_PERF_CNT_EN`: 3 branches, 1 mispredicted → `branch_cnt`=3, `mispred_cnt`=1; without the macro both read 0.

Source files
------------

// File: rtl/br_resolve.sv
// Branch/jump resolver: decodes compare results, checks the fetch prediction and
// sequences a registered redirect plus multi-cycle flush. Optional counters: BR_PERF_CNT_EN.
module br_resolve #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [1:0]        br_kind,
   input  logic [2:0]        br_funct3,
   input  logic              pred_taken,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   imm,
   input  logic [XLEN-1:0]   rs1_data,
   output logic              br_unsigned,
   input  logic              br_less,
   input  logic              br_equal,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              flush,
   output logic              misalign_exc,
   output logic              illegal_br,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t             state_reg;
   logic [FC_W-1:0]    fcnt_reg;
   logic               redirect_valid_reg;
   logic [XLEN-1:0]    redirect_pc_reg;
   logic               flush_reg;
   logic               misalign_reg;
   logic               illegal_reg;

   logic               accept;
   logic               is_cond, is_jal, is_jalr;
   logic               cond_taken, cond_legal;
   logic               illegal, taken, misaligned, mispredict, do_redirect;
   logic [XLEN-1:0]    jalr_sum, target, fall_through;

   assign br_unsigned = br_funct3[1];
   assign br_ready    = (state_reg == IDLE);
   assign accept      = br_valid & br_ready;

   assign is_cond = (br_kind == 2'b00);
   assign is_jal  = (br_kind == 2'b01);
   assign is_jalr = (br_kind == 2'b10);

   always_comb begin
      cond_taken = 1'b0;
      cond_legal = 1'b1;
      case (br_funct3)
         3'b000:         cond_taken = br_equal;
         3'b001:         cond_taken = ~br_equal;
         3'b100, 3'b110: cond_taken = br_less;
         3'b101, 3'b111: cond_taken = ~br_less;
         default:        cond_legal = 1'b0;
      endcase
   end

   assign jalr_sum     = rs1_data + imm;
   assign target       = is_jalr ? (jalr_sum & ~XLEN'(1)) : (pc + imm);
   assign fall_through = pc + XLEN'(4);

   assign illegal     = (br_kind == 2'b11) | (is_cond & ~cond_legal);
   assign taken       = is_cond ? cond_taken : 1'b1;
   assign misaligned  = taken & target[1];
   // JALR always redirects since fetch never has a reliable register target
   assign mispredict  = is_jalr | (is_jal & ~pred_taken) | (is_cond & (cond_taken != pred_taken));
   assign do_redirect = ~illegal & ~misaligned & mispredict;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg          <= IDLE;
         fcnt_reg           <= '0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
         flush_reg          <= 1'b0;
         misalign_reg       <= 1'b0;
         illegal_reg        <= 1'b0;
      end else begin
         redirect_valid_reg <= 1'b0;
         misalign_reg       <= 1'b0;
         illegal_reg        <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     illegal_reg <= 1'b1;
                  end else if (misaligned) begin
                     misalign_reg <= 1'b1;
                  end else if (mispredict) begin
                     redirect_valid_reg <= 1'b1;
                     redirect_pc_reg    <= taken ? target : fall_through;
                     flush_reg          <= 1'b1;
                     fcnt_reg           <= FC_W'(FLUSH_CYCLES - 1);
                     state_reg          <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (fcnt_reg == '0) begin
                  flush_reg <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  fcnt_reg <= fcnt_reg - FC_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;
   assign flush          = flush_reg;
   assign misalign_exc   = misalign_reg;
   assign illegal_br     = illegal_reg;

`ifdef BR_PERF_CNT_EN
   logic [CNT_W-1:0] branch_cnt_reg;
   logic [CNT_W-1:0] mispred_cnt_reg;

   // Both counters saturate rather than wrap
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         branch_cnt_reg  <= '0;
         mispred_cnt_reg <= '0;
      end else begin
         if (accept && !illegal && branch_cnt_reg != '1)
            branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
         if (accept && do_redirect && mispred_cnt_reg != '1)
            mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
      end
   end

   assign branch_cnt  = branch_cnt_reg;
   assign mispred_cnt = mispred_cnt_reg;
`else
   assign branch_cnt  = '0;
   assign mispred_cnt = '0;
`endif

endmodule
